seq_event_monitor: RTL and testbench

Downstream consumer of the one-hot run detector's `z` output (asserted for four consecutive equal `w` values). Counts detection events, tracks the current and longest `z`-high run in detector steps, and drives four active-low seven-segment displays. All counters are packed 2-digit BCD so the display path needs no binary-to-BCD conversion.

---
 rtl/seq_event_monitor.sv | 83 ++++++++
 tb/tb_seq_event_monitor.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/seq_event_monitor.sv
// Event/run statistics for the run detector's z output, kept in packed 2-digit BCD
// so the four active-low seven-segment displays can be driven directly.
module seq_event_monitor (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       step,
  input  logic       z,
  input  logic       clear,
  output logic [7:0] event_cnt,
  output logic [7:0] run_len,
  output logic [7:0] max_run,
  output logic       ovf,
  output logic [6:0] HEX3,
  output logic [6:0] HEX2,
  output logic [6:0] HEX1,
  output logic [6:0] HEX0
);

  logic       z_prev;
  logic [7:0] run_next;
  logic       rise;

  // BCD increment that holds at 99 instead of wrapping to 00
  function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h99)
      r = 8'h99;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign run_next = z ? bcd_inc_sat(run_len) : 8'h00;
  assign rise     = z & ~z_prev;

  always_ff @(posedge Clock) begin
    if (!Resetn || clear) begin
      z_prev    <= 1'b0;
      event_cnt <= 8'h00;
      run_len   <= 8'h00;
      max_run   <= 8'h00;
      ovf       <= 1'b0;
    end else if (step) begin
      z_prev  <= z;
      run_len <= run_next;
      // packed BCD orders the same as unsigned binary, so a plain compare works
      if (run_next > max_run)
        max_run <= run_next;
      if (rise) begin
        if (event_cnt == 8'h99)
          ovf <= 1'b1;
        else
          event_cnt <= bcd_inc_sat(event_cnt);
      end
    end
  end

  assign HEX3 = seg7(event_cnt[7:4]);
  assign HEX2 = seg7(event_cnt[3:0]);
  assign HEX1 = seg7(max_run[7:4]);
  assign HEX0 = seg7(max_run[3:0]);

endmodule

// File: tb/tb_seq_event_monitor.sv
// Self-checking bench for seq_event_monitor: integer reference model compared every
// cycle, directed scenarios pinned with literal values, then randomized traffic.
module tb_seq_event_monitor;

  logic       Clock = 1'b0;
  logic       Resetn, step, z, clear;
  logic [7:0] event_cnt, run_len, max_run;
  logic       ovf;
  logic [6:0] HEX3, HEX2, HEX1, HEX0;

  int compared   = 0;
  int mismatched = 0;
  bit armed      = 1'b0;

  // reference model state as plain integers
  int m_ev = 0, m_run = 0, m_mx = 0;
  bit m_ovf = 1'b0, m_zprev = 1'b0;

  logic [6:0] seg_lut [10];

  seq_event_monitor dut (
    .Clock(Clock), .Resetn(Resetn), .step(step), .z(z), .clear(clear),
    .event_cnt(event_cnt), .run_len(run_len), .max_run(max_run), .ovf(ovf),
    .HEX3(HEX3), .HEX2(HEX2), .HEX1(HEX1), .HEX0(HEX0)
  );

  always #5 Clock = ~Clock;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rn, input logic clr, input logic stp, input logic zz);
    @(negedge Clock);
    Resetn = rn;
    clear  = clr;
    step   = stp;
    z      = zz;
  endtask

  // model: events are 0->1 transitions of sampled z, runs count consecutive high samples
  always @(posedge Clock) begin
    if (!Resetn || clear) begin
      m_ev = 0; m_run = 0; m_mx = 0; m_ovf = 1'b0; m_zprev = 1'b0;
    end else if (step) begin
      if (z && !m_zprev) begin
        if (m_ev == 99) m_ovf = 1'b1;
        else m_ev = m_ev + 1;
      end
      m_run = z ? ((m_run + 1 > 99) ? 99 : m_run + 1) : 0;
      if (m_run > m_mx) m_mx = m_run;
      m_zprev = z;
    end
  end

  always @(negedge Clock) begin
    if (armed) begin
      checkOutput("event_cnt", 32'(event_cnt), 32'(to_bcd(m_ev)));
      checkOutput("run_len",   32'(run_len),   32'(to_bcd(m_run)));
      checkOutput("max_run",   32'(max_run),   32'(to_bcd(m_mx)));
      checkOutput("ovf",       32'(ovf),       32'(m_ovf));
      checkOutput("HEX3",      32'(HEX3),      32'(seg_lut[m_ev / 10]));
      checkOutput("HEX2",      32'(HEX2),      32'(seg_lut[m_ev % 10]));
      checkOutput("HEX1",      32'(HEX1),      32'(seg_lut[m_mx / 10]));
      checkOutput("HEX0",      32'(HEX0),      32'(seg_lut[m_mx % 10]));
    end
  end

  task automatic stepZ(input logic zz);
    applyStimulus(1'b1, 1'b0, 1'b1, zz);
  endtask

  task automatic idle();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic doClear();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    seg_lut = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    Resetn = 1'b0; clear = 1'b0; step = 1'b1; z = 1'b1;

    // reset held two cycles while step/z are active
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    armed = 1'b1;
    idle();
    checkOutput("rst_event_cnt", 32'(event_cnt), 32'h00);
    checkOutput("rst_run_len",   32'(run_len),   32'h00);
    checkOutput("rst_max_run",   32'(max_run),   32'h00);
    checkOutput("rst_ovf",       32'(ovf),       32'h0);
    checkOutput("rst_HEX3",      32'(HEX3),      32'h40);
    checkOutput("rst_HEX0",      32'(HEX0),      32'h40);

    // basic sequence 0,1,1,1,0,1,0
    stepZ(0); stepZ(1); stepZ(1); stepZ(1); stepZ(0); stepZ(1); stepZ(0);
    idle();
    checkOutput("seq_event_cnt", 32'(event_cnt), 32'h02);
    checkOutput("seq_run_len",   32'(run_len),   32'h00);
    checkOutput("seq_max_run",   32'(max_run),   32'h03);
    checkOutput("seq_HEX1",      32'(HEX1),      32'h40);
    checkOutput("seq_HEX0",      32'(HEX0),      32'h30);

    // BCD carry on events and on run length
    doClear();
    for (int i = 0; i < 10; i++) begin stepZ(1); stepZ(0); end
    idle();
    checkOutput("carry_event_cnt", 32'(event_cnt), 32'h10);
    for (int i = 0; i < 12; i++) stepZ(1);
    idle();
    checkOutput("carry_run_len", 32'(run_len), 32'h12);
    checkOutput("carry_max_run", 32'(max_run), 32'h12);
    checkOutput("carry_HEX2",    32'(HEX2),    32'(7'b1111001));

    // saturation of events and run length
    doClear();
    for (int i = 0; i < 100; i++) begin stepZ(1); stepZ(0); end
    idle();
    checkOutput("sat_event_cnt", 32'(event_cnt), 32'h99);
    checkOutput("sat_ovf",       32'(ovf),       32'h1);
    for (int i = 0; i < 105; i++) stepZ(1);
    idle();
    checkOutput("sat_run_len", 32'(run_len), 32'h99);
    checkOutput("sat_max_run", 32'(max_run), 32'h99);

    // z toggling without step changes nothing
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'(i % 2));
    idle();
    checkOutput("hold_event_cnt", 32'(event_cnt), 32'h99);
    checkOutput("hold_run_len",   32'(run_len),   32'h99);
    checkOutput("hold_ovf",       32'(ovf),       32'h1);

    // clear wins over a simultaneous step
    doClear();
    for (int i = 0; i < 5; i++) stepZ(1);
    idle();
    checkOutput("pre_clr_max_run", 32'(max_run), 32'h05);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    idle();
    checkOutput("clr_event_cnt", 32'(event_cnt), 32'h00);
    checkOutput("clr_run_len",   32'(run_len),   32'h00);
    checkOutput("clr_max_run",   32'(max_run),   32'h00);
    stepZ(1);
    idle();
    checkOutput("post_clr_event_cnt", 32'(event_cnt), 32'h01);
    checkOutput("post_clr_run_len",   32'(run_len),   32'h01);
    checkOutput("post_clr_max_run",   32'(max_run),   32'h01);

    // randomized traffic with occasional clear and reset
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 199) != 0), ($urandom_range(0, 79) == 0),
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
    end
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
